// File: rtl/ttl_debounce_pkg.sv
// Shared definitions for the SPDT contact debouncer: pulse FSM states and
// the synchronized contact codes {s_n, r_n}.
package ttl_debounce_pkg;

   // Pulse generator states: no pulse, set_n pulse active, reset_n pulse active
   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      PULSE_SET = 2'd1,
      PULSE_RST = 2'd2
   } state_t;

   // Contact codes as seen on {s_n, r_n} after synchronization
   localparam logic [1:0] CODE_ILLEGAL = 2'b00;
   localparam logic [1:0] CODE_SET     = 2'b01;
   localparam logic [1:0] CODE_RST     = 2'b10;
   localparam logic [1:0] CODE_HOLD    = 2'b11;

endpackage

// File: rtl/ttl_sync2.sv
// Two-flop synchronizer for one asynchronous, active-low contact line.
// Resets to 1 so an idle (open) contact reads as inactive.
module ttl_sync2 (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   // Shift the raw input through two flops to settle metastability
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments keep the two stages a true shift
      // register; blocking ones would collapse them into a single flop.
      if (rst) begin
         meta <= 1'b1;
         q    <= 1'b1;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/rs_debounce.sv
// Debounced SPDT set/reset contact pair. Each raw contact is synchronized,
// the combined code must stay constant for STABLE_CNT clocks to qualify,
// and a qualified state change updates q and emits a clean active-low
// pulse of PULSE_LEN clocks on set_n or reset_n.
module rs_debounce
   import ttl_debounce_pkg::*;
#(
   parameter int unsigned STABLE_CNT = 8,
   parameter int unsigned PULSE_LEN  = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic s_n,
   input  logic r_n,
   output logic q,
   output logic q_n,
   output logic set_n,
   output logic reset_n,
   output logic chg,
   output logic err
);

   localparam logic [7:0] CNT_MAX    = 8'(STABLE_CNT);
   localparam logic [7:0] CNT_LAST   = 8'(STABLE_CNT - 1);
   localparam logic [3:0] PULSE_LAST = 4'(PULSE_LEN - 1);

   logic       s_sync;
   logic       r_sync;
   logic [1:0] code;
   logic [1:0] code_prev;
   logic [7:0] stab_cnt;
   logic       same;
   logic       qual;
   logic       qual_set;
   logic       qual_rst;
   logic       qual_ill;
   logic       rise;
   logic       fall;

   state_t     state;
   state_t     state_nxt;
   logic [3:0] pcnt;
   logic [3:0] pcnt_nxt;

   ttl_sync2 u_sync_s (
      .clk (clk),
      .rst (rst),
      .d   (s_n),
      .q   (s_sync)
   );

   ttl_sync2 u_sync_r (
      .clk (clk),
      .rst (rst),
      .d   (r_n),
      .q   (r_sync)
   );

   assign code = {s_sync, r_sync};
   assign same = (code == code_prev);

   // Qualification fires only on the clock the counter reaches STABLE_CNT;
   // once saturated the counter no longer moves, so a held code never requalifies.
   assign qual     = same && (stab_cnt == CNT_LAST);
   assign qual_set = qual && (code == CODE_SET);
   assign qual_rst = qual && (code == CODE_RST);
   assign qual_ill = qual && (code == CODE_ILLEGAL);
   assign rise     = qual_set && !q;
   assign fall     = qual_rst && q;

   // Stability counter: count consecutive identical codes, saturating
   always_ff @(posedge clk) begin
      if (rst) begin
         code_prev <= CODE_HOLD;
         stab_cnt  <= '0;
      end else begin
         code_prev <= code;
         if (!same) begin
            stab_cnt <= '0;
         end else if (stab_cnt != CNT_MAX) begin
            stab_cnt <= stab_cnt + 8'd1;
         end
      end
   end

   // Latch state, change strobe and sticky illegal-state flag
   always_ff @(posedge clk) begin
      if (rst) begin
         q   <= 1'b0;
         chg <= 1'b0;
         err <= 1'b0;
      end else begin
         chg <= rise || fall;
         if (rise) begin
            q <= 1'b1;
         end else if (fall) begin
            q <= 1'b0;
         end
         if (qual_ill) begin
            err <= 1'b1;
         end else if (qual_set || qual_rst) begin
            err <= 1'b0;
         end
      end
   end

   // Pulse FSM state and pulse counter register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         pcnt  <= '0;
      end else begin
         state <= state_nxt;
         pcnt  <= pcnt_nxt;
      end
   end

   // Pulse FSM next state: a new change always wins and restarts the pulse,
   // which also aborts an opposite pulse still in progress.
   always_comb begin
      // NOTE: defaults first so every path assigns both outputs; otherwise
      // the unlisted cases would infer latches.
      state_nxt = state;
      pcnt_nxt  = pcnt;
      if (rise) begin
         state_nxt = PULSE_SET;
         pcnt_nxt  = PULSE_LAST;
      end else if (fall) begin
         state_nxt = PULSE_RST;
         pcnt_nxt  = PULSE_LAST;
      end else begin
         case (state)
            PULSE_SET, PULSE_RST: begin
               if (pcnt == 4'd0) begin
                  state_nxt = IDLE;
               end else begin
                  pcnt_nxt = pcnt - 4'd1;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   // Pulses decode from a single registered state, so they can never overlap
   assign set_n   = (state != PULSE_SET);
   assign reset_n = (state != PULSE_RST);
   assign q_n     = ~q;

endmodule

// File: tb/tb_rs_debounce.sv
// Directed bench for rs_debounce with STABLE_CNT=4, PULSE_LEN=2: a clean
// step updates q on the 7th edge and the pulse lasts two clocks.
module tb_rs_debounce;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic s_n = 1'b1;
   logic r_n = 1'b1;
   logic q, q_n, set_n, reset_n, chg, err;

   int n_cmp = 0;
   int n_bad = 0;

   rs_debounce #(
      .STABLE_CNT (4),
      .PULSE_LEN  (2)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .s_n     (s_n),
      .r_n     (r_n),
      .q       (q),
      .q_n     (q_n),
      .set_n   (set_n),
      .reset_n (reset_n),
      .chg     (chg),
      .err     (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Advance one rising edge and settle before sampling/driving
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Outputs that must hold while nothing is allowed to change
   task automatic quiet(input string tag, input logic exp_q, input logic exp_err);
      check({tag, ".q"}, q, exp_q);
      check({tag, ".chg"}, chg, 1'b0);
      check({tag, ".set_n"}, set_n, 1'b1);
      check({tag, ".reset_n"}, reset_n, 1'b1);
      check({tag, ".err"}, err, exp_err);
   endtask

   // set_n and reset_n must never be low together
   always @(negedge clk) begin
      check("excl", set_n | reset_n, 1'b1);
   end

   initial begin
      // Reset with a set request already present on the contacts
      s_n = 1'b0;
      r_n = 1'b1;
      rst = 1'b1;
      tick();
      tick();
      quiet("rst", 1'b0, 1'b0);
      check("rst.q_n", q_n, 1'b1);

      // Clean set step after reset: q rises on edge 7, set_n low edges 7..8
      rst = 1'b0;
      for (int e = 1; e <= 6; e++) begin
         tick();
         quiet("set_wait", 1'b0, 1'b0);
      end
      tick();
      check("set7.q", q, 1'b1);
      check("set7.q_n", q_n, 1'b0);
      check("set7.chg", chg, 1'b1);
      check("set7.set_n", set_n, 1'b0);
      check("set7.reset_n", reset_n, 1'b1);
      tick();
      check("set8.chg", chg, 1'b0);
      check("set8.set_n", set_n, 1'b0);
      tick();
      check("set9.set_n", set_n, 1'b1);
      check("set9.q", q, 1'b1);

      // Illegal code 00: err sets on edge 7, q stays 1
      s_n = 1'b0;
      r_n = 1'b0;
      for (int e = 1; e <= 6; e++) begin
         tick();
         quiet("ill_wait", 1'b1, 1'b0);
      end
      tick();
      quiet("ill7", 1'b1, 1'b1);
      for (int e = 0; e < 3; e++) begin
         tick();
         quiet("ill_hold", 1'b1, 1'b1);
      end

      // Transit code 11 qualifies but changes nothing, err stays sticky
      s_n = 1'b1;
      r_n = 1'b1;
      for (int e = 0; e < 8; e++) begin
         tick();
         quiet("hold11", 1'b1, 1'b1);
      end

      // r_n bounces every 2 clocks, shorter than STABLE_CNT: no effect
      for (int i = 0; i < 8; i++) begin
         r_n = i[1];
         tick();
         quiet("bounce", 1'b1, 1'b1);
      end

      // Settle to 10: q falls on edge 7, err clears, reset_n low edges 7..8
      r_n = 1'b0;
      for (int e = 1; e <= 6; e++) begin
         tick();
         quiet("rst_wait", 1'b1, 1'b1);
      end
      tick();
      check("clr7.q", q, 1'b0);
      check("clr7.q_n", q_n, 1'b1);
      check("clr7.chg", chg, 1'b1);
      check("clr7.reset_n", reset_n, 1'b0);
      check("clr7.set_n", set_n, 1'b1);
      check("clr7.err", err, 1'b0);
      tick();
      check("clr8.chg", chg, 1'b0);
      check("clr8.reset_n", reset_n, 1'b0);
      tick();
      check("clr9.reset_n", reset_n, 1'b1);

      // With q=0: 11 then a freshly qualified 10 held 20 clocks -> nothing
      r_n = 1'b1;
      for (int e = 0; e < 10; e++) begin
         tick();
         quiet("q0_hold11", 1'b0, 1'b0);
      end
      r_n = 1'b0;
      for (int e = 0; e < 20; e++) begin
         tick();
         quiet("q0_rst", 1'b0, 1'b0);
      end

      // Set again, then assert reset while set_n is low
      s_n = 1'b0;
      r_n = 1'b1;
      for (int e = 1; e <= 6; e++) begin
         tick();
         quiet("set2_wait", 1'b0, 1'b0);
      end
      tick();
      check("set2_7.q", q, 1'b1);
      check("set2_7.set_n", set_n, 1'b0);
      rst = 1'b1;
      tick();
      quiet("midrst", 1'b0, 1'b0);
      check("midrst.q_n", q_n, 1'b1);

      // After reset release the held 01 qualifies again on edge 7
      rst = 1'b0;
      for (int e = 1; e <= 6; e++) begin
         tick();
         quiet("post_wait", 1'b0, 1'b0);
      end
      tick();
      check("post7.q", q, 1'b1);
      check("post7.chg", chg, 1'b1);
      check("post7.set_n", set_n, 1'b0);
      tick();
      tick();
      check("post9.set_n", set_n, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/rs_debounce.md
RS_DEBOUNCE -- requirements
Module: rs_debounce

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, named clk and rst.
REQ-002 Parameter STABLE_CNT, default 8: the number of consecutive identical synchronized samples needed to qualify a contact state (range 2..255).
REQ-003 Parameter PULSE_LEN, default 2: the width, in clocks, of the set_n and reset_n output pulses (range 1..15).
REQ-004 Ports:
- clk      input   1  rising-edge clock
- rst      input   1  synchronous reset, active high
- s_n      input   1  raw SPDT "set" contact, active low, asynchronous and bouncing
- r_n      input   1  raw SPDT "reset" contact, active low, asynchronous and bouncing
- q        output  1  debounced latch state
- q_n      output  1  always the inverse of q
- set_n    output  1  clean active-low set pulse for a downstream RS latch
- reset_n  output  1  clean active-low reset pulse for a downstream RS latch
- chg      output  1  one-cycle strobe issued when q changes
- err      output  1  illegal contact state (both contacts low) is qualified

Function
REQ-005 s_n and r_n SHALL each pass through a 2-flop synchronizer before any other logic uses them.
REQ-006 The synchronized contact code {s_n,r_n} SHALL be decoded as follows:
- 01: set request
- 10: reset request
- 11: contact in transit (hold)
- 00: illegal
REQ-007 A stability counter SHALL increment on every clock in which the synchronized code equals the code of the previous clock, and SHALL clear to 0 on any change.
REQ-008 The stability counter SHALL saturate at STABLE_CNT and SHALL NOT wrap.
REQ-009 A code SHALL be "qualified" on the single clock in which the counter reaches STABLE_CNT; holding the code longer SHALL NOT requalify it.
REQ-010 Qualified 01 with q=0 SHALL set q=1, pulse chg high for one cycle, and drive set_n low for PULSE_LEN cycles.
REQ-011 Qualified 10 with q=1 SHALL set q=0, pulse chg, and drive reset_n low for PULSE_LEN cycles.
REQ-012 Qualified 01 with q=1, or qualified 10 with q=0, SHALL produce no chg and no pulse.
REQ-013 Qualified 11 SHALL leave all outputs unchanged.
REQ-014 Qualified 00 SHALL set err=1 and leave q unchanged; err SHALL remain set until a qualified 01 or 10.
REQ-015 Latency SHALL be exactly STABLE_CNT+3 rising edges from the first edge that samples a clean input step to the edge on which q and chg update; set_n/reset_n SHALL fall on that same edge.
REQ-016 FSM states SHALL be IDLE (no pulse active), PULSE_SET, and PULSE_RST, each pulse state backed by a pulse counter.
REQ-017 The FSM SHALL return to IDLE after PULSE_LEN cycles.
REQ-018 An opposite qualification during an active pulse SHALL abort that pulse and start the new one on the same edge.
REQ-019 set_n and reset_n SHALL never be low simultaneously.
REQ-020 Bounces shorter than STABLE_CNT clocks SHALL have no effect on any output.

Reset
REQ-021 Reset SHALL produce: q=0, q_n=1, set_n=1, reset_n=1, chg=0, err=0, counter=0, synchronizers=11, FSM=IDLE.
REQ-022 Reset asserted mid-pulse SHALL terminate the pulse on the next edge.
REQ-023 After reset deasserts, a constant contact input SHALL qualify STABLE_CNT+3 cycles later.

Structure
REQ-024 A shared package ttl_debounce_pkg SHALL hold the FSM state encodings and the four contact-code constants.
REQ-025 The synchronizer SHALL be a separate sub-module, ttl_sync2 (1-bit, 2-flop, reset value 1), instantiated twice.

Verification (STABLE_CNT=4, PULSE_LEN=2)
REQ-026 After reset, {s_n,r_n}=01 held -> q=1, chg=1, and set_n=0 on edge 7; set_n=1 from edge 9.
REQ-027 With q=1, r_n bounces 0/1 every 2 cycles, then settles to 10 -> no output change until the 7th edge after settling, then q=0, chg=1, and reset_n low for 2 cycles.
REQ-028 {s_n,r_n}=00 held -> err=1 after 7 edges with q unchanged; a later 10 held -> err=0 and q=0.
REQ-029 With q=0, qualified 10 held for 20 cycles -> no chg and no pulse.
REQ-030 rst asserted during the set_n low pulse -> set_n=1 and q=0 on the next edge.
